// File: rtl/uart_core_if.sv
// -----------------------------------------------------------------------------
// uart_core_if
//   Bundles the user-facing and line-facing signals of uart_core.
//   Handshake: a word on tx_data is transferred on every rising clk edge where
//   tx_valid && tx_ready are both high; tx_valid seen while tx_ready is low has
//   no effect. rx_valid is a one-clock pulse with no back-pressure.
//
//   Signals
//     tx_data        word to send (DATA_BITS)
//     tx_valid       request to send tx_data
//     tx_ready       transmitter idle, can accept
//     tx             serial out, idle high
//     rx             serial in, asynchronous to clk
//     rx_data        last received word (DATA_BITS)
//     rx_valid       one-clock pulse: rx_data and flags are new
//     rx_parity_err  parity mismatch on last word
//     rx_frame_err   first stop bit sampled low on last word
//     tx_state_dbg   current TX FSM state (debug)
//     rx_state_dbg   current RX FSM state (debug)
//   Modports: slave = the UART core, master = the user / line side.
// -----------------------------------------------------------------------------
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic [2:0]           tx_state_dbg;
    logic [2:0]           rx_state_dbg;

    modport slave (
        input  tx_data, tx_valid, rx,
        output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err,
               tx_state_dbg, rx_state_dbg
    );

    modport master (
        output tx_data, tx_valid, rx,
        input  tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err,
               tx_state_dbg, rx_state_dbg
    );
endinterface

// File: rtl/uart_core.sv
// -----------------------------------------------------------------------------
// uart_core
//   Full-duplex UART. Independent TX and RX engines share one free-running
//   oversampling tick (a clock enable, no derived clocks). Data bits, parity
//   and stop bits are parameters.
//
//   Ports
//     clk   in  system clock, rising edge
//     rst   in  asynchronous, active-low reset
//     bus   uart_core_if.slave: tx_data/tx_valid/tx_ready handshake, tx line,
//           rx line, rx_data/rx_valid/rx_parity_err/rx_frame_err, debug states
//
//   TX: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, every bit lasts
//   OVERSAMPLE ticks (STOP lasts STOP_BITS*OVERSAMPLE ticks), LSB first.
//   RX: start edge detected on a tick, confirmed at half a bit, then sampled at
//   each bit centre. Only the first stop bit is checked; a low stop bit parks
//   the receiver in WAIT_HIGH until the line idles, so a break gives one word.
// -----------------------------------------------------------------------------
module uart_core #(
    parameter int CLK_FREQUENCY = 10000000,
    parameter int BAUD_RATE     = 9600,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input logic        clk,
    input logic        rst,
    uart_core_if.slave bus
);

    localparam int DIV     = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TXT_MAX = STOP_BITS * OVERSAMPLE;
    localparam int TW      = $clog2(TXT_MAX);
    localparam int RW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_core: CLK_FREQUENCY/(BAUD_RATE*OVERSAMPLE) must be >= 1");
        end
        if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
            $error("uart_core: OVERSAMPLE must be even and >= 4");
        end
        if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
            $error("uart_core: DATA_BITS must be 5..9");
        end
        if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_par
            $error("uart_core: PARITY must be 0, 1 or 2");
        end
        if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
            $error("uart_core: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // Parity bit that makes the total count of ones odd (PARITY=1) or even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        if (PARITY == 1) begin
            return ~(^d);
        end
        return ^d;
    endfunction

    // ---------------------------------------------------------------- tick
    logic [CW-1:0] div_q, div_d;
    logic          tick;

    assign tick  = (div_q == CW'(DIV - 1));
    assign div_d = tick ? '0 : div_q + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    tx_state_t            tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic [TW-1:0]        tx_tick_q, tx_tick_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic                 tx_q, tx_d;
    logic                 tx_bit_end;
    logic                 tx_stop_end;

    // A bit ends on the tick that completes its tick count.
    assign tx_bit_end  = tick && (tx_tick_q == TW'(OVERSAMPLE - 1));
    assign tx_stop_end = tick && (tx_tick_q == TW'(TXT_MAX - 1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_valid) begin
                    // Start bit goes out on the accepting edge itself.
                    tx_shift_d = bus.tx_data;
                    tx_par_d   = calc_parity(bus.tx_data);
                    tx_tick_d  = '0;
                    tx_d       = 1'b0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else if (tick) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_tick_d = '0;
                    if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            tx_d       = tx_par_q;
                            tx_state_d = TX_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            tx_state_d = TX_STOP;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else if (tick) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_tick_d  = '0;
                    tx_d       = 1'b1;
                    tx_state_d = TX_STOP;
                end else if (tick) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                end
            end
            TX_STOP: begin
                tx_d = 1'b1;
                if (tx_stop_end) begin
                    tx_tick_d  = '0;
                    tx_state_d = TX_IDLE;
                end else if (tick) begin
                    tx_tick_d = tx_tick_q + TW'(1);
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    assign bus.tx           = tx_q;
    assign bus.tx_ready     = (tx_state_q == TX_IDLE);
    assign bus.tx_state_dbg = tx_state_q;

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    logic                 rx_meta_q, rx_sync_q;
    rx_state_t            rx_state_q, rx_state_d;
    logic [RW-1:0]        rx_tick_q, rx_tick_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_half;
    logic                 rx_centre;

    // Half a bit after the detecting tick the start bit is re-checked; from
    // then on every full bit period lands on a bit centre.
    assign rx_half   = tick && (rx_tick_q == RW'(OVERSAMPLE / 2 - 1));
    assign rx_centre = tick && (rx_tick_q == RW'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rx_sync_q) begin
                    rx_tick_d  = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_half) begin
                    rx_tick_d = '0;
                    if (!rx_sync_q) begin
                        rx_bit_d   = '0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else if (tick) begin
                    rx_tick_d = rx_tick_q + RW'(1);
                end
            end
            RX_DATA: begin
                if (rx_centre) begin
                    rx_tick_d  = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BW'(DATA_BITS - 1)) begin
                        rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BW'(1);
                    end
                end else if (tick) begin
                    rx_tick_d = rx_tick_q + RW'(1);
                end
            end
            RX_PARITY: begin
                if (rx_centre) begin
                    rx_tick_d  = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end else if (tick) begin
                    rx_tick_d = rx_tick_q + RW'(1);
                end
            end
            RX_STOP: begin
                if (rx_centre) begin
                    rx_tick_d  = '0;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_ferr_d  = ~rx_sync_q;
                    rx_perr_d  = (PARITY != 0) ? (calc_parity(rx_shift_q) != rx_par_q) : 1'b0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
                end else if (tick) begin
                    rx_tick_d = rx_tick_q + RW'(1);
                end
            end
            RX_WAIT_HIGH: begin
                // Held-low line: no new start until the line has idled.
                if (tick && rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
    assign bus.rx_state_dbg  = rx_state_q;

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
module tb_uart_core;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int OS     = 16;
  localparam int DIV    = 10;
  localparam int BITC   = 160;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // dut_n: 8N1 with tx looped to rx; dut_e: 8E1, rx from bench or its own tx
  uart_core_if #(.DATA_BITS(8)) if_n ();
  uart_core_if #(.DATA_BITS(8)) if_e ();
  logic loop_e = 1'b0;
  logic drv_rx_e = 1'b1;

  assign if_n.rx = if_n.tx;
  assign if_e.rx = loop_e ? if_e.tx : drv_rx_e;

  uart_core #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
              .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_n (.clk(clk), .rst(rst_n), .bus(if_n));

  uart_core #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
              .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_e (.clk(clk), .rst(rst_n), .bus(if_e));

  // Tick phase as the bench sees it: clocks since reset release, mod DIV.
  int ph;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 0;
    else ph <= (ph == DIV - 1) ? 0 : ph + 1;
  end

  // ------------------------------------------------------------ checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  // Expected rx record {frame_err, parity_err, data} for a frame on the line.
  function automatic logic [9:0] rx_expect(input logic [7:0] d, input logic par_bit,
                                           input logic stop_bit, input int mode);
    int ones;
    logic perr;
    ones = $countones(d) + (mode != 0 ? int'(par_bit) : 0);
    perr = 1'b0;
    if (mode == 2) perr = (ones % 2) != 0;
    if (mode == 1) perr = (ones % 2) == 0;
    return {~stop_bit, perr, d};
  endfunction

  // Even parity bit: makes total ones even.
  function automatic logic even_bit(input logic [7:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  // ------------------------------------------------------------ scoreboard
  logic [9:0] exp_n_q[$];
  logic [9:0] exp_e_q[$];
  int rxv_n = 0;
  int rxv_e = 0;

  always @(negedge clk) begin
    if (rst_n && if_n.rx_valid) begin
      rxv_n++;
      check("rx_n_pending", 32'(exp_n_q.size() != 0), 1);
      if (exp_n_q.size() != 0)
        check("rx_n_word", {if_n.rx_frame_err, if_n.rx_parity_err, if_n.rx_data}, exp_n_q.pop_front());
    end
    if (rst_n && if_e.rx_valid) begin
      rxv_e++;
      check("rx_e_pending", 32'(exp_e_q.size() != 0), 1);
      if (exp_e_q.size() != 0)
        check("rx_e_word", {if_e.rx_frame_err, if_e.rx_parity_err, if_e.rx_data}, exp_e_q.pop_front());
    end
  end

  // ------------------------------------------------------------ drivers
  function automatic logic txv(input int sel);
    return (sel != 0) ? if_e.tx : if_n.tx;
  endfunction

  function automatic logic txr(input int sel);
    return (sel != 0) ? if_e.tx_ready : if_n.tx_ready;
  endfunction

  task automatic set_tx(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin if_e.tx_valid = v; if_e.tx_data = d; end
    else begin if_n.tx_valid = v; if_n.tx_data = d; end
  endtask

  task automatic tx_send(input int sel, input logic [7:0] d);
    int g;
    @(negedge clk);
    set_tx(sel, 1'b1, d);
    g = 0;
    while (txr(sel) !== 1'b1 && g < 4000) begin @(negedge clk); g++; end
    check("tx_accept", txr(sel), 1);
    @(posedge clk);
    #1 set_tx(sel, 1'b0, d);
  endtask

  // Line-level decoder: waits for a start bit, samples each bit centre.
  task automatic tx_decode(input int sel, output logic [7:0] d, output logic p, output logic s);
    int g;
    d = '0; p = 1'b0; s = 1'b0;
    g = 0;
    while (txv(sel) !== 1'b0 && g < 6000) begin @(negedge clk); g++; end
    check("tx_start_seen", txv(sel), 0);
    repeat (BITC / 2) @(negedge clk);
    check("tx_start_mid", txv(sel), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (BITC) @(negedge clk);
      d[i] = txv(sel);
    end
    if (sel != 0) begin
      repeat (BITC) @(negedge clk);
      p = txv(sel);
    end
    repeat (BITC) @(negedge clk);
    s = txv(sel);
  endtask

  task automatic rx_frame_e(input logic [7:0] d, input logic par, input logic stop);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      drv_rx_e = f[i];
      repeat (BITC) @(negedge clk);
    end
    drv_rx_e = 1'b1;
  endtask

  // One full tx frame on a DUT, decoded on the line and checked.
  task automatic tx_frame_check(input int sel, input logic [7:0] w, input string tag);
    logic [7:0] d;
    logic p, s;
    if (sel != 0) exp_e_q.push_back({2'b00, w});
    else exp_n_q.push_back({2'b00, w});
    fork
      tx_send(sel, w);
      tx_decode(sel, d, p, s);
    join
    check({tag, "_data"}, d, w);
    if (sel != 0) check({tag, "_par"}, p, even_bit(w));
    check({tag, "_stop"}, s, 1);
    repeat (100) @(negedge clk);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [9:0] seq;
    int bad[10];
    int low, c0, g;
    logic [7:0] w, d;
    logic p, s, bp, bs;

    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    // reset values
    check("rst_n_tx", if_n.tx, 1);
    check("rst_n_ready", if_n.tx_ready, 1);
    check("rst_n_rxdata", if_n.rx_data, 0);
    check("rst_n_rxvalid", if_n.rx_valid, 0);
    check("rst_n_perr", if_n.rx_parity_err, 0);
    check("rst_n_ferr", if_n.rx_frame_err, 0);
    check("rst_e_tx", if_e.tx, 1);
    check("rst_e_ready", if_e.tx_ready, 1);
    check("rst_e_rxdata", if_e.rx_data, 0);
    check("rst_e_rxvalid", if_e.rx_valid, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1. 8N1 0xA5, accept aligned to a tick: exact 160-clk bits, 1600-clk busy
    exp_n_q.push_back({2'b00, 8'hA5});
    seq = {1'b1, 8'hA5, 1'b0};
    g = 0;
    while (ph != DIV - 1 && g < 20) begin @(negedge clk); g++; end
    set_tx(0, 1'b1, 8'hA5);
    @(posedge clk);
    #1 set_tx(0, 1'b0, 8'h00);
    check("t1_ready_drop", if_n.tx_ready, 0);
    check("t1_tx_start", if_n.tx, 0);
    low = 0;
    for (int b = 0; b < 10; b++) bad[b] = 0;
    for (int k = 0; k < 1700; k++) begin
      @(negedge clk);
      if (k < 1600 && if_n.tx !== seq[k / BITC]) bad[k / BITC]++;
      if (if_n.tx_ready === 1'b0) low++;
    end
    for (int b = 0; b < 10; b++) check($sformatf("t1_bit%0d", b), bad[b], 0);
    check("t1_ready_low", low, 1600);

    // 2. 8E1 loopback 0x5A: parity bit 0, clean receive
    loop_e = 1'b1;
    c0 = rxv_e;
    tx_frame_check(1, 8'h5A, "t2");
    check("t2_rxv", rxv_e - c0, 1);
    loop_e = 1'b0;
    repeat (40) @(negedge clk);

    // 3. 0x01 with wrong parity bit
    c0 = rxv_e;
    exp_e_q.push_back(rx_expect(8'h01, 1'b0, 1'b1, 2));
    rx_frame_e(8'h01, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("t3_rxv", rxv_e - c0, 1);

    // 4. break: 20 bit times low -> exactly one word, then a clean 0x3C
    c0 = rxv_e;
    exp_e_q.push_back(rx_expect(8'h00, 1'b0, 1'b0, 2));
    drv_rx_e = 1'b0;
    repeat (20 * BITC) @(negedge clk);
    check("t4_break_rxv", rxv_e - c0, 1);
    drv_rx_e = 1'b1;
    repeat (40) @(negedge clk);
    exp_e_q.push_back(rx_expect(8'h3C, even_bit(8'h3C), 1'b1, 2));
    rx_frame_e(8'h3C, even_bit(8'h3C), 1'b1);
    repeat (20) @(negedge clk);
    check("t4_after_rxv", rxv_e - c0, 2);

    // 5. 50-clk glitch rejected, then 0x81
    c0 = rxv_e;
    drv_rx_e = 1'b0;
    repeat (50) @(negedge clk);
    drv_rx_e = 1'b1;
    repeat (2 * BITC) @(negedge clk);
    check("t5_glitch_rxv", rxv_e - c0, 0);
    exp_e_q.push_back(rx_expect(8'h81, even_bit(8'h81), 1'b1, 2));
    rx_frame_e(8'h81, even_bit(8'h81), 1'b1);
    repeat (20) @(negedge clk);
    check("t5_rxv", rxv_e - c0, 1);

    // back-to-back: tx_valid held, tx_data changed right after accept
    exp_n_q.push_back({2'b00, 8'h96});
    exp_n_q.push_back({2'b00, 8'h3E});
    c0 = rxv_n;
    fork
      begin
        @(negedge clk);
        set_tx(0, 1'b1, 8'h96);
        @(posedge clk);
        #1 set_tx(0, 1'b1, 8'h3E);
        g = 0;
        while (if_n.tx_ready !== 1'b1 && g < 3000) begin @(negedge clk); g++; end
        check("b2b_ready_back", if_n.tx_ready, 1);
        @(posedge clk);
        #1 check("b2b_accept_at_once", if_n.tx_ready, 0);
        set_tx(0, 1'b0, 8'h00);
      end
      begin
        tx_decode(0, d, p, s);
        check("b2b_w0", d, 8'h96);
        check("b2b_w0_stop", s, 1);
        tx_decode(0, d, p, s);
        check("b2b_w1", d, 8'h3E);
        check("b2b_w1_stop", s, 1);
      end
    join
    repeat (100) @(negedge clk);
    check("b2b_rxv", rxv_n - c0, 2);

    // tx_valid while busy is ignored
    c0 = rxv_n;
    exp_n_q.push_back({2'b00, 8'hC3});
    fork
      tx_send(0, 8'hC3);
      tx_decode(0, d, p, s);
      begin
        repeat (400) @(negedge clk);
        set_tx(0, 1'b1, 8'h00);
        repeat (3) @(negedge clk);
        set_tx(0, 1'b0, 8'h00);
      end
    join
    check("ign_data", d, 8'hC3);
    repeat (3 * BITC) @(negedge clk);
    check("ign_rxv", rxv_n - c0, 1);
    check("ign_ready", if_n.tx_ready, 1);

    // random tx on both DUTs (dut_e looped back)
    loop_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 40)) @(negedge clk);
      tx_frame_check(int'($urandom_range(0, 1)), w, $sformatf("rtx%0d", i));
    end
    loop_e = 1'b0;
    repeat (40) @(negedge clk);

    // random rx frames on dut_e with occasional parity/stop errors
    for (int i = 0; i < 6; i++) begin
      w  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      c0 = rxv_e;
      exp_e_q.push_back(rx_expect(w, even_bit(w) ^ bp, ~bs, 2));
      rx_frame_e(w, even_bit(w) ^ bp, ~bs);
      repeat (20) @(negedge clk);
      check($sformatf("rrx%0d_rxv", i), rxv_e - c0, 1);
      repeat ($urandom_range(1, 100)) @(negedge clk);
    end

    // 6a. abort during a start bit
    c0 = rxv_n;
    tx_send(0, 8'h00);
    repeat (50) @(negedge clk);
    check("t6a_tx_low", if_n.tx, 0);
    rst_n = 1'b0;
    #1;
    check("t6a_tx", if_n.tx, 1);
    check("t6a_ready", if_n.tx_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    check("t6a_no_rx", rxv_n - c0, 0);

    // 6. abort during data bit 3 of 0xFF
    tx_send(0, 8'hFF);
    repeat (4 * BITC + 80) @(negedge clk);
    check("t6_busy", if_n.tx_ready, 0);
    rst_n = 1'b0;
    #1;
    check("t6_tx", if_n.tx, 1);
    check("t6_ready", if_n.tx_ready, 1);
    check("t6_rxdata", if_n.rx_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * BITC) @(negedge clk);
    check("t6_no_partial", rxv_n - c0, 0);
    tx_frame_check(0, 8'h0F, "t6_after");
    check("t6_after_rxv", rxv_n - c0, 1);

    check("exp_n_left", exp_n_q.size(), 0);
    check("exp_e_left", exp_e_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
